// File: rtl/bist_session_sched.sv
// Round-robin scheduler for a single shared BIST engine: it launches one session at a time,
// compares the engine's signature against the golden value, and returns pass/fail with a watchdog abort.
module bist_session_sched #(
    parameter int NREQ = 4,
    parameter int SIGW = 16,
    parameter int TMO  = 255
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] DONE,
    output logic            PASS,
    output logic            TIMEOUT,
    output logic            BUSY,
    output logic            ENG_START,
    input  logic            ENG_INIT,
    input  logic            ENG_RUNNING,
    input  logic            ENG_FINISH,
    input  logic [SIGW-1:0] SIG,
    input  logic [SIGW-1:0] GOLDEN
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW  = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ABORT,
        S_REPORT
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [SIGW-1:0] golden_q, golden_d;
    logic            pass_q, pass_d;
    logic            tmo_q, tmo_d;

    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;
    logic            found;
    logic            wd_expired;

    // The engine's phase indicator is deliberately not used: the watchdog counts every RUN cycle.
    logic            unused_running;
    assign unused_running = ENG_RUNNING;

    // Walk downward so the last hit, i.e. the first requester at or after rr_q, wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(rr_q) + k) % NREQ);
            if (REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign wd_expired = (wd_q == WDW'(TMO));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        wd_d     = wd_q;
        golden_d = golden_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    gidx_d      = pick;
                    golden_d    = GOLDEN;
                    wd_d        = '0;
                    pass_d      = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (ENG_INIT) begin
                    wd_d    = '0;
                    state_d = S_RUN;
                end else if (wd_expired) begin
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RUN: begin
                // A FINISH on the last watchdog cycle still counts as a completed session.
                if (ENG_FINISH) begin
                    pass_d  = (SIG == golden_q);
                    state_d = S_REPORT;
                end else if (wd_expired) begin
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_ABORT: begin
                pass_d  = 1'b0;
                tmo_d   = 1'b1;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                rr_d    = IDXW'((int'(gidx_q) + 1) % NREQ);
                gnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            wd_q     <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            wd_q     <= wd_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            tmo_q    <= tmo_d;
        end
    end

    assign GNT       = gnt_q;
    assign DONE      = (state_q == S_REPORT) ? gnt_q : '0;
    assign PASS      = (state_q == S_REPORT) && pass_q;
    assign TIMEOUT   = (state_q == S_REPORT) && tmo_q;
    assign BUSY      = (state_q != S_IDLE);
    assign ENG_START = (state_q == S_LAUNCH);

endmodule
